// File: rtl/sap_pkg.sv
// Shared SAP-1 definitions: run-controller states, default widths and
// control-word bit positions used by the microcode controller.
package sap_pkg;

    localparam int unsigned SAP_ADDR_W     = 4;
    localparam int unsigned SAP_DATA_W     = 8;
    localparam int unsigned SAP_CNT_W      = 16;
    localparam int unsigned SAP_STAGE_W    = 3;
    localparam int unsigned SAP_LAST_STAGE = 5;

    localparam int unsigned CW_W       = 12;
    localparam int unsigned CW_HLT     = 11;
    localparam int unsigned CW_PC_INC  = 10;
    localparam int unsigned CW_PC_OE   = 9;
    localparam int unsigned CW_MAR_LD  = 8;
    localparam int unsigned CW_MEM_EN  = 7;
    localparam int unsigned CW_IR_LD   = 6;
    localparam int unsigned CW_IR_OE   = 5;
    localparam int unsigned CW_A_LD    = 4;
    localparam int unsigned CW_A_OE    = 3;
    localparam int unsigned CW_ALU_SUB = 2;
    localparam int unsigned CW_ALU_OE  = 1;
    localparam int unsigned CW_OUT_LD  = 0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_STEP  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_LOAD  = 3'd4
    } run_state_e;

    // States in which the core is allowed to advance.
    function automatic logic state_runs(run_state_e s);
        return (s == ST_RUN) || (s == ST_STEP) || (s == ST_DRAIN);
    endfunction

endpackage

// File: rtl/sap_ram_mux.sv
// Program-RAM port mux: loader owns the RAM only while load_gnt is high.
module sap_ram_mux #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic              load_gnt,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata
);

    always_comb begin
        ram_addr  = cpu_addr;
        ram_we    = 1'b0;
        ram_wdata = '0;
        if (load_gnt) begin
            ram_addr  = load_addr;
            ram_we    = load_we;
            ram_wdata = load_data;
        end
    end

endmodule

// File: rtl/sap_run_ctrl.sv
// SAP-1 run/halt/single-step scheduler and program-RAM arbiter between
// the core and an external loader; the RAM changes hands only at
// instruction boundaries.
module sap_run_ctrl
    import sap_pkg::*;
#(
    parameter int unsigned ADDR_W     = SAP_ADDR_W,
    parameter int unsigned DATA_W     = SAP_DATA_W,
    parameter int unsigned LAST_STAGE = SAP_LAST_STAGE,
    parameter int unsigned CNT_W      = SAP_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [SAP_STAGE_W-1:0] stage,
    input  logic                   hlt_sig,
    input  logic                   run_req,
    input  logic                   stop_req,
    input  logic                   step_req,
    input  logic                   load_req,
    input  logic                   load_we,
    input  logic [ADDR_W-1:0]      load_addr,
    input  logic [DATA_W-1:0]      load_data,
    input  logic [ADDR_W-1:0]      cpu_addr,
    output logic                   cpu_en,
    output logic                   cpu_clr,
    output logic                   load_gnt,
    output logic [ADDR_W-1:0]      ram_addr,
    output logic                   ram_we,
    output logic [DATA_W-1:0]      ram_wdata,
    output logic                   halted,
    output logic [CNT_W-1:0]       instr_cnt
);

    run_state_e       state_q,    state_d;
    logic             need_clr_q, need_clr_d;
    logic             halted_q,   halted_d;
    logic             clr_q,      clr_d;
    logic             en_q,       en_d;
    logic             gnt_q,      gnt_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic             boundary;
    logic             hlt_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            need_clr_q <= 1'b1;
            halted_q   <= 1'b0;
            clr_q      <= 1'b0;
            en_q       <= 1'b0;
            gnt_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            need_clr_q <= need_clr_d;
            halted_q   <= halted_d;
            clr_q      <= clr_d;
            en_q       <= en_d;
            gnt_q      <= gnt_d;
            cnt_q      <= cnt_d;
        end
    end

    // Next-state, flag and counter logic; HLT outranks every other event.
    always_comb begin
        state_d    = state_q;
        need_clr_d = need_clr_q;
        halted_d   = halted_q;
        clr_d      = 1'b0;
        cnt_d      = cnt_q;
        boundary   = en_q && (stage == SAP_STAGE_W'(LAST_STAGE));
        hlt_hit    = en_q && hlt_sig;

        unique case (state_q)
            ST_IDLE: begin
                if (load_req) begin
                    state_d = ST_LOAD;
                end else if (run_req || step_req) begin
                    state_d = run_req ? ST_RUN : ST_STEP;
                    if (need_clr_q || halted_q) begin
                        clr_d      = 1'b1;
                        need_clr_d = 1'b0;
                        halted_d   = 1'b0;
                        cnt_d      = '0;
                    end
                end
            end
            ST_RUN: begin
                if (hlt_hit) begin
                    state_d  = ST_IDLE;
                    halted_d = 1'b1;
                end else begin
                    if (boundary) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (load_req || stop_req) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_STEP: begin
                if (hlt_hit) begin
                    state_d  = ST_IDLE;
                    halted_d = 1'b1;
                end else if (boundary) begin
                    state_d = ST_IDLE;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            ST_DRAIN: begin
                if (hlt_hit) begin
                    state_d  = ST_IDLE;
                    halted_d = 1'b1;
                end else if (boundary) begin
                    state_d = load_req ? ST_LOAD : ST_IDLE;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            ST_LOAD: begin
                if (!load_req) begin
                    state_d    = ST_IDLE;
                    need_clr_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        en_d  = state_runs(state_d);
        gnt_d = (state_d == ST_LOAD);
    end

    sap_ram_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram_mux (
        .load_gnt  (gnt_q),
        .load_we   (load_we),
        .load_addr (load_addr),
        .load_data (load_data),
        .cpu_addr  (cpu_addr),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata)
    );

    assign cpu_en    = en_q;
    assign cpu_clr   = clr_q;
    assign load_gnt  = gnt_q;
    assign halted    = halted_q;
    assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_sap_run_ctrl.sv
// Directed bench for sap_run_ctrl with a small stage/PC core model whose
// third instruction (address 2) is HLT.
module tb_sap_run_ctrl;

    logic        clk;
    logic        rst_n;
    logic [2:0]  stage;
    logic        hlt_sig;
    logic        run_req;
    logic        stop_req;
    logic        step_req;
    logic        load_req;
    logic        load_we;
    logic [3:0]  load_addr;
    logic [7:0]  load_data;
    logic [3:0]  cpu_addr;
    logic        cpu_en;
    logic        cpu_clr;
    logic        load_gnt;
    logic [3:0]  ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic        halted;
    logic [15:0] instr_cnt;

    logic [3:0]  m_pc;
    int          nvec;
    int          nerr;
    int          en_cnt;
    logic        done;
    logic        hit;

    sap_run_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .stage     (stage),
        .hlt_sig   (hlt_sig),
        .run_req   (run_req),
        .stop_req  (stop_req),
        .step_req  (step_req),
        .load_req  (load_req),
        .load_we   (load_we),
        .load_addr (load_addr),
        .load_data (load_data),
        .cpu_addr  (cpu_addr),
        .cpu_en    (cpu_en),
        .cpu_clr   (cpu_clr),
        .load_gnt  (load_gnt),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .halted    (halted),
        .instr_cnt (instr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core model: clear wins over enable; PC advances after stage 5.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage <= 3'd0;
            m_pc  <= 4'd0;
        end else if (cpu_clr) begin
            stage <= 3'd0;
            m_pc  <= 4'd0;
        end else if (cpu_en) begin
            if (stage == 3'd5) begin
                stage <= 3'd0;
                m_pc  <= m_pc + 4'd1;
            end else begin
                stage <= stage + 3'd1;
            end
        end
    end

    assign hlt_sig = (stage == 3'd3) && (m_pc == 4'd2);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        nvec      = 0;
        nerr      = 0;
        rst_n     = 1'b0;
        run_req   = 1'b0;
        stop_req  = 1'b0;
        step_req  = 1'b0;
        load_req  = 1'b0;
        load_we   = 1'b0;
        load_addr = 4'h0;
        load_data = 8'h00;
        cpu_addr  = 4'h9;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;

        chk("rst_cpu_en", 32'(cpu_en), 32'd0);
        chk("rst_cpu_clr", 32'(cpu_clr), 32'd0);
        chk("rst_load_gnt", 32'(load_gnt), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_instr_cnt", 32'(instr_cnt), 32'd0);

        // Program load
        load_req = 1'b1;
        tick();
        chk("load_gnt_up", 32'(load_gnt), 32'd1);
        chk("load_cpu_en", 32'(cpu_en), 32'd0);
        load_we = 1'b1; load_addr = 4'h0; load_data = 8'h0E;
        #1;
        chk("ld0_we", 32'(ram_we), 32'd1);
        chk("ld0_addr", 32'(ram_addr), 32'h0);
        chk("ld0_data", 32'(ram_wdata), 32'h0E);
        tick();
        load_addr = 4'h1; load_data = 8'h1F;
        #1;
        chk("ld1_addr", 32'(ram_addr), 32'h1);
        chk("ld1_data", 32'(ram_wdata), 32'h1F);
        load_we = 1'b0; load_req = 1'b0;
        tick();
        chk("load_gnt_down", 32'(load_gnt), 32'd0);
        load_we = 1'b1;
        #1;
        chk("idle_we_blocked", 32'(ram_we), 32'd0);
        chk("idle_wdata_zero", 32'(ram_wdata), 32'd0);
        chk("idle_addr_cpu", 32'(ram_addr), 32'h9);
        load_we = 1'b0;

        // Run LDA, ADD, HLT
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        chk("run_clr", 32'(cpu_clr), 32'd1);
        chk("run_en", 32'(cpu_en), 32'd1);
        done = 1'b0;
        for (int i = 0; i < 60; i++) begin
            hit = cpu_en & hlt_sig;
            tick();
            if (hit) begin
                done = 1'b1;
                break;
            end
        end
        chk("hlt_seen", 32'(done), 32'd1);
        chk("hlt_cpu_en", 32'(cpu_en), 32'd0);
        chk("hlt_halted", 32'(halted), 32'd1);
        chk("hlt_instr_cnt", 32'(instr_cnt), 32'd2);

        // Restart after HLT, then load request mid-instruction
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        chk("restart_clr", 32'(cpu_clr), 32'd1);
        chk("restart_halted", 32'(halted), 32'd0);
        chk("restart_cnt", 32'(instr_cnt), 32'd0);
        done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (stage == 3'd1 && !cpu_clr) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        chk("reach_stage1", 32'(done), 32'd1);
        load_req  = 1'b1;
        load_addr = 4'h3;
        tick();
        chk("drain_cpu_en", 32'(cpu_en), 32'd1);
        chk("drain_no_gnt", 32'(load_gnt), 32'd0);
        chk("drain_addr_cpu", 32'(ram_addr), 32'h9);
        done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (stage == 3'd5) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        chk("reach_stage5", 32'(done), 32'd1);
        chk("stage5_no_gnt", 32'(load_gnt), 32'd0);
        tick();
        chk("drain_gnt", 32'(load_gnt), 32'd1);
        chk("drain_en_off", 32'(cpu_en), 32'd0);
        chk("drain_cnt", 32'(instr_cnt), 32'd1);
        chk("drain_addr_ld", 32'(ram_addr), 32'h3);
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        chk("load_step_ign_gnt", 32'(load_gnt), 32'd1);
        chk("load_step_ign_en", 32'(cpu_en), 32'd0);
        load_req = 1'b0;
        tick();
        chk("reload_idle_gnt", 32'(load_gnt), 32'd0);
        chk("reload_idle_en", 32'(cpu_en), 32'd0);

        // Single step after reload: clear pulse, then six stages
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        chk("step1_clr", 32'(cpu_clr), 32'd1);
        chk("step1_cnt_clr", 32'(instr_cnt), 32'd0);
        en_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!cpu_en) break;
            if (!cpu_clr) en_cnt++;
        end
        chk("step1_en_cycles", 32'(en_cnt), 32'd6);
        chk("step1_cnt", 32'(instr_cnt), 32'd1);

        // Second step with a stray pulse while stepping
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        chk("step2_no_clr", 32'(cpu_clr), 32'd0);
        chk("step2_en", 32'(cpu_en), 32'd1);
        en_cnt = 1;
        for (int i = 0; i < 20; i++) begin
            step_req = (en_cnt == 3);
            tick();
            if (!cpu_en) break;
            en_cnt++;
        end
        step_req = 1'b0;
        chk("step2_en_cycles", 32'(en_cnt), 32'd6);
        chk("step2_cnt", 32'(instr_cnt), 32'd2);
        tick();
        chk("step2_stray_ignored", 32'(cpu_en), 32'd0);

        // Async reset in DRAIN
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        chk("run2_no_clr", 32'(cpu_clr), 32'd0);
        chk("run2_cnt_kept", 32'(instr_cnt), 32'd2);
        stop_req = 1'b1;
        tick();
        chk("stop_drain_en", 32'(cpu_en), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_cpu_en", 32'(cpu_en), 32'd0);
        chk("arst_cpu_clr", 32'(cpu_clr), 32'd0);
        chk("arst_load_gnt", 32'(load_gnt), 32'd0);
        chk("arst_halted", 32'(halted), 32'd0);
        chk("arst_instr_cnt", 32'(instr_cnt), 32'd0);
        chk("arst_ram_we", 32'(ram_we), 32'd0);
        stop_req = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/sap_run_ctrl.md
Name: sap_run_ctrl

Overview:
- Run/halt/single-step scheduler for the SAP-1 core. It also arbitrates the 16x8 program RAM between the CPU and an external program loader.
- Gates core advance with cpu_en and only releases the RAM to the loader at instruction boundaries.
- Restarts the core cleanly after HLT or after a program reload.
- Sits between the top level, the microcode controller (stage, HLT bit) and the RAM.

Parameters:
- ADDR_W, 4, RAM address width.
- DATA_W, 8, RAM data width.
- LAST_STAGE, 5, index of the final T-state of each instruction.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- stage  in  3  current T-state from the microcode controller.
- hlt_sig  in  1  HLT bit of the control word.
- run_req  in  1  level; request free-running execution.
- stop_req  in  1  level; request stop at the next instruction boundary.
- step_req  in  1  single-cycle pulse; execute exactly one instruction.
- load_req  in  1  level; loader requests the RAM.
- load_we  in  1  loader write strobe; honoured only while load_gnt=1.
- load_addr  in  ADDR_W  loader address.
- load_data  in  DATA_W  loader write data.
- cpu_addr  in  ADDR_W  MAR output of the core.
- cpu_en  out  1  core clock enable.
- cpu_clr  out  1  one-cycle pulse; resets PC and stage.
- load_gnt  out  1  RAM granted to the loader.
- ram_addr  out  ADDR_W  muxed RAM address.
- ram_we  out  1  RAM write enable.
- ram_wdata  out  DATA_W  RAM write data.
- halted  out  1  core stopped on HLT (sticky).
- instr_cnt  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, need_clr=1.
  - cpu_en=0, cpu_clr=0, load_gnt=0, halted=0, instr_cnt=0.
- States: IDLE, RUN, STEP, DRAIN, LOAD. Outputs are decoded from registered state: cpu_en=1 in RUN, STEP and DRAIN; load_gnt=1 only in LOAD.
- boundary = cpu_en & (stage==LAST_STAGE), sampled on posedge.
- hlt_hit = cpu_en & hlt_sig.
- IDLE transitions, priority load_req > run_req > step_req:
  - load_req -> LOAD.
  - run_req -> RUN.
  - step_req -> STEP.
  - If need_clr=1 or halted=1 when leaving IDLE for RUN/STEP: cpu_clr pulses for that one cycle; need_clr and halted clear.
  - step_req pulses while not in IDLE are ignored.
- RUN:
  - hlt_hit -> IDLE, halted=1; takes precedence over everything.
  - load_req or stop_req -> DRAIN.
  - boundary: instr_cnt+1.
- STEP:
  - hlt_hit -> IDLE, halted=1.
  - boundary -> IDLE, instr_cnt+1.
- DRAIN:
  - hlt_hit -> IDLE, halted=1.
  - boundary -> LOAD if load_req is still high, else IDLE; instr_cnt+1.
- LOAD:
  - ram_addr=load_addr, ram_we=load_we, ram_wdata=load_data.
  - load_req=0 -> IDLE, need_clr=1.
  - run/step requests are ignored until exit.
- Outside LOAD: ram_addr=cpu_addr, ram_we=0, ram_wdata=0. The mux is combinational on registered state, so there is no cycle in which both parties drive the RAM.
- Counter rules:
  - instr_cnt wraps modulo 2^CNT_W.
  - instr_cnt clears on cpu_clr.
  - HLT is not counted as retired.
- A boundary and hlt_hit in the same cycle cannot occur (HLT is a stage-3 event); hlt_hit wins if it ever does.
- Reset mid-LOAD drops load_gnt immediately (async). The partially written program is kept in RAM, and need_clr=1.

Decomposition:
- Shared package sap_pkg:
  - state enum.
  - LAST_STAGE.
  - control-word bit indices (HLT=11, MEM_EN=7, ...) shared with the microcode controller.
- One sub-module, sap_ram_mux: the combinational address/data/we mux keyed on load_gnt.
- FSM, flags and counter stay in the top module.

Test Plan:
- Reset, load: load_req=1 -> load_gnt=1 next cycle. Write 0x0E to addr 0 and 0x1F to addr 1. Drop load_req -> IDLE, need_clr=1, ram_we never high outside LOAD.
- Run to HLT: run_req=1 -> cpu_clr 1-cycle pulse and cpu_en=1. Program LDA, ADD, HLT -> instr_cnt=2, halted=1, cpu_en=0 the cycle after stage=3 with hlt_sig=1.
- Single step: step_req pulse -> cpu_en high for exactly 6 stage values (0..5), then IDLE with instr_cnt+1. A second pulse during STEP is ignored.
- Load during run: load_req rises at stage=1 -> DRAIN until stage=5 -> load_gnt asserts the next cycle; ram_addr follows load_addr.
- Restart after HLT: run_req with halted=1 -> cpu_clr pulse, halted=0, instr_cnt=0.
- Async reset mid-DRAIN -> all outputs at reset values without a clock edge.
